// File: rtl/sobel_window3x3.sv
`default_nettype none
// ============================================================================
// sobel_window3x3 : 3x3 column window with |Gx|+|Gy| Sobel magnitude, 3 stages
// Revision 1.0
// ============================================================================
module sobel_window3x3 #(
  parameter int COLORDEPTH = 8,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] col_i [2:0],
  input  logic                  dv_i,
  input  logic                  line_end,
  input  logic                  frame_start,
  output logic [COLORDEPTH-1:0] pix_o,
  output logic                  dv_o
);

  localparam int                    W         = COLORDEPTH + 3;
  localparam logic [COLORDEPTH-1:0] C_PIX_MAX = '1;

  logic [COLORDEPTH-1:0] win_q [2:0][2:0];
  logic [COLORDEPTH-1:0] win_d [2:0][2:0];
  logic [1:0]            col_cnt_q, col_cnt_d;
  logic [1:0]            row_cnt_q, row_cnt_d;
  logic                  ok1_q, ok1_d, dv1_q, dv1_d;
  logic signed [W-1:0]   gx_q, gx_d, gy_q, gy_d;
  logic                  ok2_q, ok2_d, dv2_q, dv2_d;
  logic [COLORDEPTH-1:0] pix_q, pix_d;
  logic                  dv3_q, dv3_d;

  logic [W-1:0]          w_abs_gx, w_abs_gy, w_mag, w_mag_sh;

  function automatic logic signed [W-1:0] zext(input logic [COLORDEPTH-1:0] p);
    return signed'({3'b000, p});
  endfunction

  // Stage 1: window shift, column/row bookkeeping and the pixel-ok flag
  always_comb begin
    win_d     = win_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    ok1_d     = ok1_q;
    dv1_d     = dv_i;
    if (line_end) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_d[r][c] = '0;
        end
      end
      col_cnt_d = '0;
      ok1_d     = 1'b0;
    end else if (dv_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
        win_d[r][2] = col_i[r];
      end
      if (col_cnt_q != 2'd3) begin
        col_cnt_d = col_cnt_q + 2'd1;
      end
      ok1_d = (col_cnt_d == 2'd3) && (row_cnt_q >= 2'd2);
    end
    if (frame_start) begin
      row_cnt_d = '0;
    end else if (line_end && (row_cnt_q != 2'd3)) begin
      row_cnt_d = row_cnt_q + 2'd1;
    end
  end

  // Stage 2: signed gradients; ok is qualified by valid so gaps output 0
  always_comb begin
    gx_d  = (zext(win_q[0][2]) + (zext(win_q[1][2]) <<< 1) + zext(win_q[2][2]))
          - (zext(win_q[0][0]) + (zext(win_q[1][0]) <<< 1) + zext(win_q[2][0]));
    gy_d  = (zext(win_q[0][0]) + (zext(win_q[0][1]) <<< 1) + zext(win_q[0][2]))
          - (zext(win_q[2][0]) + (zext(win_q[2][1]) <<< 1) + zext(win_q[2][2]));
    ok2_d = ok1_q & dv1_q;
    dv2_d = dv1_q;
  end

  // Stage 3: magnitude, gain shift and saturation
  always_comb begin
    w_abs_gx = gx_q[W-1] ? unsigned'(-gx_q) : unsigned'(gx_q);
    w_abs_gy = gy_q[W-1] ? unsigned'(-gy_q) : unsigned'(gy_q);
    w_mag    = w_abs_gx + w_abs_gy;
    w_mag_sh = w_mag >> SHIFT;
    pix_d    = '0;
    if (ok2_q) begin
      pix_d = (|w_mag_sh[W-1:COLORDEPTH]) ? C_PIX_MAX : w_mag_sh[COLORDEPTH-1:0];
    end
    dv3_d = dv2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      ok1_q     <= 1'b0;
      dv1_q     <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      ok2_q     <= 1'b0;
      dv2_q     <= 1'b0;
      pix_q     <= '0;
      dv3_q     <= 1'b0;
    end else begin
      win_q     <= win_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      ok1_q     <= ok1_d;
      dv1_q     <= dv1_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      ok2_q     <= ok2_d;
      dv2_q     <= dv2_d;
      pix_q     <= pix_d;
      dv3_q     <= dv3_d;
    end
  end

  assign pix_o = pix_q;
  assign dv_o  = dv3_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window3x3.sv
`default_nettype none
// ============================================================================
// tb_sobel_window3x3 : scoreboard bench, three DUTs at SHIFT = 0, 2 and 3
// Revision 1.0
// ============================================================================
module tb_sobel_window3x3;

  localparam int CD = 8;

  typedef struct packed {
    int cyc;
    int e0;
    int e2;
    int e3;
    bit has_k;
    int k0;
    int k2;
    int k3;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, dv_i, line_end, frame_start;
  logic [CD-1:0] col_i [2:0];
  logic [CD-1:0] pix_s0, pix_s2, pix_s3;
  logic          dv_s0, dv_s2, dv_s3;

  always #5 clk = ~clk;

  sobel_window3x3 #(.COLORDEPTH(CD), .SHIFT(0)) u_dut_s0 (
    .clk(clk), .rst(rst), .col_i(col_i), .dv_i(dv_i), .line_end(line_end),
    .frame_start(frame_start), .pix_o(pix_s0), .dv_o(dv_s0));
  sobel_window3x3 #(.COLORDEPTH(CD), .SHIFT(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .col_i(col_i), .dv_i(dv_i), .line_end(line_end),
    .frame_start(frame_start), .pix_o(pix_s2), .dv_o(dv_s2));
  sobel_window3x3 #(.COLORDEPTH(CD), .SHIFT(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .col_i(col_i), .dv_i(dv_i), .line_end(line_end),
    .frame_start(frame_start), .pix_o(pix_s3), .dv_o(dv_s3));

  exp_t sbq [$];
  exp_t mon_e;
  bit   hist [0:4095];
  int   mw [3][3];
  int   mcol, mrow;
  int   cyc = 8;
  int   dv_cnt = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   want_k = 1'b0;
  int   k0, k2, k3;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int expv(input int m, input int s);
    int v;
    v = m >> s;
    return (v > 255) ? 255 : v;
  endfunction

  // One clock of stimulus; the reference model and scoreboard advance with it.
  task automatic step(input bit dv, input bit le, input bit fs, input bit r,
                      input int bot, input int mid, input int top);
    exp_t en;
    int   gx, gy, m;
    bit   ok;
    @(posedge clk);
    #1;
    dv_i        = dv;
    line_end    = le;
    frame_start = fs;
    rst         = r;
    col_i[0]    = bot[CD-1:0];
    col_i[1]    = mid[CD-1:0];
    col_i[2]    = top[CD-1:0];
    cyc++;
    hist[cyc] = dv && !r;
    if (r) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) mw[i][j] = 0;
      mcol = 0;
      mrow = 0;
      hist[cyc-1] = 1'b0;
      hist[cyc-2] = 1'b0;
      while (sbq.size() > 0 && sbq[$].cyc >= cyc - 2) void'(sbq.pop_back());
    end else begin
      ok = 1'b0;
      m  = 0;
      if (le) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) mw[i][j] = 0;
        mcol = 0;
      end else if (dv) begin
        for (int i = 0; i < 3; i++) begin
          mw[i][0] = mw[i][1];
          mw[i][1] = mw[i][2];
        end
        mw[0][2] = bot;
        mw[1][2] = mid;
        mw[2][2] = top;
        if (mcol < 3) mcol++;
        ok = (mcol >= 3) && (mrow >= 2);
        gx = (mw[0][2] + 2*mw[1][2] + mw[2][2]) - (mw[0][0] + 2*mw[1][0] + mw[2][0]);
        gy = (mw[0][0] + 2*mw[0][1] + mw[0][2]) - (mw[2][0] + 2*mw[2][1] + mw[2][2]);
        m  = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
      end
      if (fs) mrow = 0;
      else if (le && mrow < 3) mrow++;
      if (dv) begin
        en.cyc   = cyc;
        en.e0    = ok ? expv(m, 0) : 0;
        en.e2    = ok ? expv(m, 2) : 0;
        en.e3    = ok ? expv(m, 3) : 0;
        en.has_k = want_k;
        en.k0    = k0;
        en.k2    = k2;
        en.k3    = k3;
        sbq.push_back(en);
      end
    end
    want_k = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic px(input int bot, input int mid, input int top);
    step(1'b1, 1'b0, 1'b0, 1'b0, bot, mid, top);
  endtask

  task automatic eol();
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic sof();
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic setk(input int a, input int b, input int c);
    want_k = 1'b1;
    k0 = a;
    k2 = b;
    k3 = c;
  endtask

  // mode 1: every output must be 0; mode 2: valid ramp gradient from pixel 2
  task automatic ramp_line(input bit gaps, input int mode);
    for (int p = 0; p < 8; p++) begin
      if (mode == 1) setk(0, 0, 0);
      if (mode == 2) begin
        if (p >= 2) setk(80, 20, 10);
        else        setk(0, 0, 0);
      end
      px(10*(p+1), 10*(p+1), 10*(p+1));
      if (gaps) idle(1);
    end
    eol();
  endtask

  task automatic zero_line();
    for (int p = 0; p < 8; p++) begin
      setk(0, 0, 0);
      px(0, 0, 0);
    end
    eol();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("dv_s0", {31'b0, dv_s0}, {31'b0, hist[cyc-3]});
      chk("dv_s2", {31'b0, dv_s2}, {31'b0, hist[cyc-3]});
      chk("dv_s3", {31'b0, dv_s3}, {31'b0, hist[cyc-3]});
      if (dv_s0 === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          dv_cnt++;
          chk("pix_s0", {24'b0, pix_s0}, mon_e.e0);
          chk("pix_s2", {24'b0, pix_s2}, mon_e.e2);
          chk("pix_s3", {24'b0, pix_s3}, mon_e.e3);
          if (mon_e.has_k) begin
            chk("const_s0", {24'b0, pix_s0}, mon_e.k0);
            chk("const_s2", {24'b0, pix_s2}, mon_e.k2);
            chk("const_s3", {24'b0, pix_s3}, mon_e.k3);
          end
        end
      end
    end
  end

  initial begin
    int cnt0;
    rst = 1'b1;
    dv_i = 1'b0;
    line_end = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) col_i[i] = '0;
    mcol = 0;
    mrow = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) mw[i][j] = 0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_dv", {31'b0, dv_s0}, 32'd0);
    chk("reset_pix_s0", {24'b0, pix_s0}, 32'd0);
    chk("reset_pix_s3", {24'b0, pix_s3}, 32'd0);
    idle(2);

    // flat image: no gradient anywhere, 40 outputs
    cnt0 = dv_cnt;
    sof();
    for (int l = 0; l < 5; l++) begin
      for (int p = 0; p < 8; p++) begin
        setk(0, 0, 0);
        px(100, 100, 100);
      end
      eol();
    end
    idle(5);
    chk("flat_dv_count", dv_cnt - cnt0, 32'd40);

    // horizontal ramp
    sof();
    ramp_line(1'b0, 1);
    ramp_line(1'b0, 1);
    ramp_line(1'b0, 2);
    ramp_line(1'b0, 2);

    // vertical step at column 4
    sof();
    zero_line();
    zero_line();
    for (int p = 0; p < 8; p++) begin
      if (p == 4 || p == 5) setk(255, 255, 127);
      if (p >= 6)           setk(0, 0, 0);
      if (p < 4) px(0, 0, 0);
      else       px(255, 255, 255);
    end
    eol();

    // horizontal step: bottom row 200, upper rows 0
    sof();
    zero_line();
    zero_line();
    for (int p = 0; p < 8; p++) begin
      if (p >= 2) setk(255, 200, 100);
      else        setk(0, 0, 0);
      px(200, 0, 0);
    end
    eol();

    // ramp with one-cycle gaps between pixels
    sof();
    ramp_line(1'b1, 1);
    ramp_line(1'b1, 1);
    ramp_line(1'b1, 2);

    // reset in the middle of line 3
    sof();
    ramp_line(1'b0, 1);
    ramp_line(1'b0, 1);
    ramp_line(1'b0, 2);
    for (int p = 0; p < 4; p++) begin
      setk((p >= 2) ? 80 : 0, (p >= 2) ? 20 : 0, (p >= 2) ? 10 : 0);
      px(10*(p+1), 10*(p+1), 10*(p+1));
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 50, 50, 50);
    idle(1);
    @(negedge clk);
    chk("rst_mid_dv", {31'b0, dv_s0}, 32'd0);
    chk("rst_mid_pix", {24'b0, pix_s0}, 32'd0);
    for (int p = 0; p < 3; p++) begin
      setk(0, 0, 0);
      px(70, 70, 70);
    end
    eol();
    sof();
    ramp_line(1'b0, 1);
    ramp_line(1'b0, 1);
    ramp_line(1'b0, 2);

    // line_end together with dv_i: column dropped, next line restarts
    sof();
    ramp_line(1'b0, 1);
    ramp_line(1'b0, 1);
    for (int p = 0; p < 5; p++) begin
      setk((p >= 2) ? 80 : 0, (p >= 2) ? 20 : 0, (p >= 2) ? 10 : 0);
      px(10*(p+1), 10*(p+1), 10*(p+1));
    end
    setk(0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 60, 60, 60);
    ramp_line(1'b0, 2);

    // frame_start with line_end: row count restarts at 0
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
    ramp_line(1'b0, 1);
    ramp_line(1'b0, 1);
    ramp_line(1'b0, 2);

    idle(6);
    chk("drain", sbq.size(), 32'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
